// File: rtl/timer_dev_if.sv
// Bridge-to-timer device port: address, gated write, write data, read data and IRQ.
// The bridge drives through the master modport; the timer responds through slave.
interface timer_dev_if #(
  parameter int ADDR_BITS = 32
) ();
  logic [ADDR_BITS-1:0] Addr;
  logic                 WE;
  logic [31:0]          Din;
  logic [31:0]          Dout;
  logic                 IRQ;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT), one-shot or auto-reload, maskable IRQ.
// Writes land at the clock edge; reads are combinational; the bridge is never stalled.
module timer_dev #(
  parameter int ADDR_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic [ADDR_BITS-1:0] addr_w;
  logic [1:0]           sel;
  logic                 wr_ctrl;
  logic                 wr_preset;
  logic                 unused_addr_bits;

  assign addr_w           = bus.Addr;
  assign sel              = addr_w[3:2];
  assign unused_addr_bits = ^{addr_w[ADDR_BITS-1:4], addr_w[1:0]};
  assign wr_ctrl          = bus.WE && (sel == 2'd0);
  assign wr_preset        = bus.WE && (sel == 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;

    if (wr_preset) begin
      preset_d = bus.Din;
    end
    // Clear first so a same-edge terminal count below re-sets the flag.
    if (wr_ctrl) begin
      irq_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q == 32'd0) begin
          state_d = S_INT;
          irq_d   = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        if (ctrl_q[2:1] == 2'd1) begin
          irq_d   = 1'b0;
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A software CTRL write overrides the one-shot En clear.
    if (wr_ctrl) begin
      ctrl_d = bus.Din[3:0];
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (sel)
      2'd0:    bus.Dout = {28'd0, ctrl_q};
      2'd1:    bus.Dout = preset_q;
      2'd2:    bus.Dout = count_q;
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: expectations queued as stimulus is applied, drained per cycle.
module tb_timer_dev;

  localparam int SEL_IRQ = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  exp_t sb_q[$];

  timer_dev_if #(.ADDR_BITS(32)) bus ();

  timer_dev #(.ADDR_BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every queued expectation and compare against the live DUT output.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == SEL_IRQ) begin
        obs = {31'd0, bus.IRQ};
      end else begin
        bus.Addr = 32'(e.sel) << 2;
        #1;
        obs = bus.Dout;
      end
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int word, input logic [31:0] data);
    bus.Addr = 32'(word) << 2;
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  function automatic logic [31:0] oneshot_cnt(input int k, input int n, input logic [31:0] prev);
    if (k < 2) return prev;
    if (k - 2 >= n) return 32'd0;
    return 32'(n - (k - 2));
  endfunction

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b1;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;

    // Reset values
    #12;
    push("rst_irq", SEL_IRQ, 32'd0);
    for (int w = 0; w < 4; w++) push($sformatf("rst_w%0d", w), w, 32'd0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    cyc();
    push("post_rst_irq", SEL_IRQ, 32'd0);
    push("post_rst_cnt", 2, 32'd0);
    drain();

    // One-shot, N=3, IM=1
    wr(1, 32'd3);
    wr(0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      push($sformatf("os_cnt_k%0d", k), 2, oneshot_cnt(k, 3, 32'd0));
      push($sformatf("os_irq_k%0d", k), SEL_IRQ, (k >= 6) ? 32'd1 : 32'd0);
      drain();
    end
    push("os_ctrl", 0, 32'h8);
    drain();
    wr(0, 32'h8);
    push("os_irq_clr", SEL_IRQ, 32'd0);
    drain();

    // PRESET=0 boundary
    wr(1, 32'd0);
    wr(0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      push($sformatf("p0_irq_k%0d", k), SEL_IRQ, (k >= 3) ? 32'd1 : 32'd0);
      push($sformatf("p0_cnt_k%0d", k), 2, 32'd0);
      drain();
    end
    wr(0, 32'h0);
    push("p0_irq_clr", SEL_IRQ, 32'd0);
    drain();

    // Auto-reload, N=2: period 5
    wr(1, 32'd2);
    wr(0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      int p;
      p = (k - 1) % 5;
      cyc();
      push($sformatf("ar_irq_k%0d", k), SEL_IRQ, (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
      push($sformatf("ar_cnt_k%0d", k), 2, (p == 1) ? 32'd2 : (p == 2) ? 32'd1 : 32'd0);
      drain();
    end
    wr(0, 32'h0);
    push("ar_irq_stop", SEL_IRQ, 32'd0);
    drain();
    cyc();
    cyc();

    // Masked: flag sets but IRQ stays low
    wr(1, 32'd1);
    wr(0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      push($sformatf("mask_irq_k%0d", k), SEL_IRQ, 32'd0);
      drain();
    end
    push("mask_ctrl", 0, 32'h0);
    drain();

    // CTRL write on the flag-set edge: set wins, IM now 1
    wr(0, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      push($sformatf("sw_irq_k%0d", k), SEL_IRQ, 32'd0);
      drain();
    end
    wr(0, 32'h8);
    push("sw_irq_set", SEL_IRQ, 32'd1);
    push("sw_ctrl", 0, 32'h8);
    drain();
    for (int k = 0; k < 3; k++) begin
      cyc();
      push($sformatf("sw_irq_hold%0d", k), SEL_IRQ, 32'd1);
      drain();
    end
    wr(0, 32'h0);
    push("sw_irq_clr", SEL_IRQ, 32'd0);
    drain();

    // Stop mid-count, ignored writes, restart reloads
    wr(1, 32'd10);
    wr(0, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      push($sformatf("st_cnt_k%0d", k), 2, oneshot_cnt(k, 10, 32'd0));
      drain();
    end
    wr(0, 32'h0);
    push("st_cnt_stop", 2, 32'd6);
    drain();
    for (int k = 0; k < 6; k++) begin
      cyc();
      push($sformatf("st_cnt_hold%0d", k), 2, 32'd6);
      drain();
    end
    wr(2, 32'h55);
    push("st_cnt_ro", 2, 32'd6);
    drain();
    wr(3, 32'hFFFF_FFFF);
    push("st_w3", 3, 32'd0);
    push("st_preset", 1, 32'd10);
    push("st_ctrl", 0, 32'd0);
    drain();
    wr(1, 32'd4);
    push("st_cnt_nopre", 2, 32'd6);
    drain();
    wr(0, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      push($sformatf("re_cnt_k%0d", k), 2, oneshot_cnt(k, 4, 32'd6));
      drain();
    end
    wr(0, 32'h0);

    // Async reset mid-count, mode 1, N=5
    wr(1, 32'd5);
    wr(0, 32'hB);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      push($sformatf("mr_cnt_k%0d", k), 2, oneshot_cnt(k, 5, 32'd2));
      drain();
    end
    #2;
    reset = 1'b1;
    #1;
    push("mr_irq", SEL_IRQ, 32'd0);
    push("mr_ctrl", 0, 32'd0);
    push("mr_preset", 1, 32'd0);
    push("mr_count", 2, 32'd0);
    drain();
    cyc();
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      push($sformatf("mr_irq_low%0d", k), SEL_IRQ, 32'd0);
      push($sformatf("mr_cnt_low%0d", k), 2, 32'd0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
